// File: rtl/mc_ctrl_if.sv
// Control/status bundle between mc_ctrl (master) and the R-type datapath (slave).
interface mc_ctrl_if;
    logic        run;
    logic        imem_ack;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rd;
    logic        imem_req;
    logic        ir_we;
    logic        pc_we;
    logic        reg_write;
    logic [2:0]  aluop;
    logic        busy;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] instret;
    logic [31:0] cycles;

    modport master (
        input  run, imem_ack, op, funct, rd,
        output imem_req, ir_we, pc_we, reg_write, aluop, busy, trap, trap_cause, instret, cycles
    );

    modport slave (
        output run, imem_ack, op, funct, rd,
        input  imem_req, ir_we, pc_we, reg_write, aluop, busy, trap, trap_cause, instret, cycles
    );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FETCH/DECODE/EXEC/WB sequencer; MC_CTRL_PERF_EN adds instret/cycles counters.
// Latency: 4 cycles per instruction plus one per fetch wait state; imem_ack stalls FETCH, run gates new fetches.
module mc_ctrl #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input logic    clock,
    input logic    reset,
    mc_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_TRAP
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic [2:0] aluop_q;
    logic [1:0] cause_q;
    logic       legal;
    logic       timeout_hit;
    logic       busy_w;

    always_comb begin
        legal = 1'b0;
        if (bus.op == 6'b000000) begin
            case (bus.funct)
                6'b100000, 6'b100001, 6'b101010,
                6'b100011, 6'b100100, 6'b100101: legal = 1'b1;
                default:                         legal = 1'b0;
            endcase
        end
    end

    // The current FETCH cycle is the TIMEOUT-th one once wait_cnt+1 reaches it.
    assign timeout_hit = (TIMEOUT != 8'd0) &&
                         (({1'b0, wait_cnt} + 9'd1) == {1'b0, TIMEOUT});

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
            aluop_q  <= 3'b000;
            cause_q  <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.run) begin
                        state    <= S_FETCH;
                        wait_cnt <= 8'd0;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        state <= S_DECODE;
                    end else if (timeout_hit) begin
                        state   <= S_TRAP;
                        cause_q <= 2'b10;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        aluop_q <= bus.funct[2:0];
                        state   <= S_EXEC;
                    end else begin
                        state   <= S_TRAP;
                        cause_q <= 2'b01;
                    end
                end
                S_EXEC: state <= S_WB;
                S_WB: begin
                    if (bus.run) begin
                        state    <= S_FETCH;
                        wait_cnt <= 8'd0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_TRAP:  state <= S_TRAP;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy_w         = (state != S_IDLE) && (state != S_TRAP);
    assign bus.busy       = busy_w;
    assign bus.imem_req   = (state == S_FETCH);
    assign bus.ir_we      = (state == S_FETCH) && bus.imem_ack;
    assign bus.pc_we      = (state == S_WB);
    assign bus.reg_write  = (state == S_WB) && (bus.rd != 5'd0);
    assign bus.aluop      = aluop_q;
    assign bus.trap       = (state == S_TRAP);
    assign bus.trap_cause = cause_q;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] instret_q;
    logic [31:0] cycles_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            instret_q <= 32'd0;
            cycles_q  <= 32'd0;
        end else begin
            if (state == S_WB) instret_q <= instret_q + 32'd1;
            if (busy_w)        cycles_q  <= cycles_q + 32'd1;
        end
    end

    assign bus.instret = instret_q;
    assign bus.cycles  = cycles_q;
`else
    assign bus.instret = 32'd0;
    assign bus.cycles  = 32'd0;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed per-cycle vector table plus a back-to-back pipeline sequence for mc_ctrl (TIMEOUT=4).
module tb_mc_ctrl;
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
`ifdef MC_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic        rst, run, ack;
        logic [5:0]  op, funct;
        logic [4:0]  rd;
        logic        req, irwe, pcwe, rw;
        logic [2:0]  aluop;
        logic        busy, trap;
        logic [1:0]  cause;
        logic [31:0] instret, cycles;
        logic        chk;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    always #5 clock = ~clock;

    mc_ctrl_if ifc();
    mc_ctrl #(.TIMEOUT(8'd4)) dut (.clock(clock), .reset(reset), .bus(ifc));

    function automatic vec_t mk(
        input logic rst, input logic run, input logic ack,
        input logic [5:0] op, input logic [5:0] funct, input logic [4:0] rd,
        input logic req, input logic irwe, input logic pcwe, input logic rw,
        input logic [2:0] aluop, input logic busy, input logic trap, input logic [1:0] cause,
        input int ir, input int cy, input logic chk);
        vec_t v;
        v.rst = rst; v.run = run; v.ack = ack; v.op = op; v.funct = funct; v.rd = rd;
        v.req = req; v.irwe = irwe; v.pcwe = pcwe; v.rw = rw; v.aluop = aluop;
        v.busy = busy; v.trap = trap; v.cause = cause;
        v.instret = PERF ? ir : 0;
        v.cycles  = PERF ? cy : 0;
        v.chk = chk;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0; ifc.run = 1'b0; ifc.imem_ack = 1'b0;
        ifc.op = OP_R; ifc.funct = F_ADD; ifc.rd = 5'd3;

        //          rst run ack op     funct  rd  req we pc rw alu busy trap cause ir cy chk
        vecs.push_back(mk(0, 0, 0, OP_R,   F_ADD, 3,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0));
        vecs.push_back(mk(1, 0, 0, OP_R,   F_ADD, 3,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1));
        vecs.push_back(mk(1, 1, 1, OP_R,   F_ADD, 3,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1));
        vecs.push_back(mk(1, 1, 1, OP_R,   F_ADD, 3,  1, 1, 0, 0, 0, 1, 0, 0, 0,  0, 1));
        vecs.push_back(mk(1, 1, 1, OP_R,   F_ADD, 3,  0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 1));
        vecs.push_back(mk(1, 1, 1, OP_R,   F_ADD, 3,  0, 0, 0, 0, 0, 1, 0, 0, 0,  2, 1));
        vecs.push_back(mk(1, 1, 1, OP_R,   F_ADD, 3,  0, 0, 1, 1, 0, 1, 0, 0, 0,  3, 1));
        vecs.push_back(mk(1, 1, 0, OP_R,   F_OR,  5,  1, 0, 0, 0, 0, 1, 0, 0, 1,  4, 1));
        vecs.push_back(mk(1, 1, 0, OP_R,   F_OR,  5,  1, 0, 0, 0, 0, 1, 0, 0, 1,  5, 1));
        vecs.push_back(mk(1, 1, 0, OP_R,   F_OR,  5,  1, 0, 0, 0, 0, 1, 0, 0, 1,  6, 1));
        vecs.push_back(mk(1, 1, 1, OP_R,   F_OR,  5,  1, 1, 0, 0, 0, 1, 0, 0, 1,  7, 1));
        vecs.push_back(mk(1, 1, 0, OP_R,   F_OR,  5,  0, 0, 0, 0, 0, 1, 0, 0, 1,  8, 1));
        vecs.push_back(mk(1, 0, 0, OP_R,   F_OR,  5,  0, 0, 0, 0, 5, 1, 0, 0, 1,  9, 1));
        vecs.push_back(mk(1, 0, 0, OP_R,   F_OR,  5,  0, 0, 1, 1, 5, 1, 0, 0, 1, 10, 1));
        vecs.push_back(mk(1, 0, 0, OP_R,   F_OR,  5,  0, 0, 0, 0, 5, 0, 0, 0, 2, 11, 1));
        vecs.push_back(mk(1, 1, 0, OP_R,   F_SLT, 0,  0, 0, 0, 0, 5, 0, 0, 0, 2, 11, 1));
        vecs.push_back(mk(1, 1, 1, OP_R,   F_SLT, 0,  1, 1, 0, 0, 5, 1, 0, 0, 2, 11, 1));
        vecs.push_back(mk(1, 1, 1, OP_R,   F_SLT, 0,  0, 0, 0, 0, 5, 1, 0, 0, 2, 12, 1));
        vecs.push_back(mk(1, 1, 1, OP_R,   F_SLT, 0,  0, 0, 0, 0, 2, 1, 0, 0, 2, 13, 1));
        vecs.push_back(mk(1, 1, 1, OP_R,   F_SLT, 0,  0, 0, 1, 0, 2, 1, 0, 0, 2, 14, 1));
        vecs.push_back(mk(1, 1, 1, OP_BEQ, F_ADD, 3,  1, 1, 0, 0, 2, 1, 0, 0, 3, 15, 1));
        vecs.push_back(mk(1, 1, 1, OP_BEQ, F_ADD, 3,  0, 0, 0, 0, 2, 1, 0, 0, 3, 16, 1));
        vecs.push_back(mk(1, 1, 1, OP_BEQ, F_ADD, 3,  0, 0, 0, 0, 2, 0, 1, 1, 3, 17, 1));
        vecs.push_back(mk(1, 1, 1, OP_BEQ, F_ADD, 3,  0, 0, 0, 0, 2, 0, 1, 1, 3, 17, 1));
        vecs.push_back(mk(0, 1, 1, OP_BEQ, F_ADD, 3,  0, 0, 0, 0, 2, 0, 1, 1, 3, 17, 1));
        vecs.push_back(mk(1, 1, 0, OP_R,   F_SUB, 3,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1));
        vecs.push_back(mk(1, 1, 1, OP_R,   F_SUB, 3,  1, 1, 0, 0, 0, 1, 0, 0, 0,  0, 1));
        vecs.push_back(mk(1, 1, 1, OP_R,   F_SUB, 3,  0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 1));
        vecs.push_back(mk(1, 1, 1, OP_R,   F_SUB, 3,  0, 0, 0, 0, 0, 0, 1, 1, 0,  2, 1));
        vecs.push_back(mk(0, 1, 1, OP_R,   F_SUB, 3,  0, 0, 0, 0, 0, 0, 1, 1, 0,  2, 1));
        vecs.push_back(mk(1, 1, 0, OP_R,   F_ADD, 3,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1));
        vecs.push_back(mk(1, 1, 0, OP_R,   F_ADD, 3,  1, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1));
        vecs.push_back(mk(1, 1, 0, OP_R,   F_ADD, 3,  1, 0, 0, 0, 0, 1, 0, 0, 0,  1, 1));
        vecs.push_back(mk(1, 1, 0, OP_R,   F_ADD, 3,  1, 0, 0, 0, 0, 1, 0, 0, 0,  2, 1));
        vecs.push_back(mk(1, 1, 0, OP_R,   F_ADD, 3,  1, 0, 0, 0, 0, 1, 0, 0, 0,  3, 1));
        vecs.push_back(mk(1, 1, 0, OP_R,   F_ADD, 3,  0, 0, 0, 0, 0, 0, 1, 2, 0,  4, 1));
        vecs.push_back(mk(0, 1, 0, OP_R,   F_ADD, 3,  0, 0, 0, 0, 0, 0, 1, 2, 0,  4, 1));
        vecs.push_back(mk(1, 1, 0, OP_R,   F_ADD, 3,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1));
        vecs.push_back(mk(0, 1, 0, OP_R,   F_ADD, 3,  1, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1));
        vecs.push_back(mk(1, 0, 1, OP_R,   F_ADD, 3,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1));
        vecs.push_back(mk(1, 0, 0, OP_R,   F_ADD, 3,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1));

        foreach (vecs[i]) begin
            @(negedge clock);
            reset = vecs[i].rst; ifc.run = vecs[i].run; ifc.imem_ack = vecs[i].ack;
            ifc.op = vecs[i].op; ifc.funct = vecs[i].funct; ifc.rd = vecs[i].rd;
            #1;
            if (vecs[i].chk) begin
                check("imem_req",   i, 32'(ifc.imem_req),   32'(vecs[i].req));
                check("ir_we",      i, 32'(ifc.ir_we),      32'(vecs[i].irwe));
                check("pc_we",      i, 32'(ifc.pc_we),      32'(vecs[i].pcwe));
                check("reg_write",  i, 32'(ifc.reg_write),  32'(vecs[i].rw));
                check("aluop",      i, 32'(ifc.aluop),      32'(vecs[i].aluop));
                check("busy",       i, 32'(ifc.busy),       32'(vecs[i].busy));
                check("trap",       i, 32'(ifc.trap),       32'(vecs[i].trap));
                check("trap_cause", i, 32'(ifc.trap_cause), 32'(vecs[i].cause));
                check("instret",    i, ifc.instret,         vecs[i].instret);
                check("cycles",     i, ifc.cycles,          vecs[i].cycles);
            end
        end

        // Back-to-back AND rd=7 with ack always high: 4-cycle cadence.
        @(negedge clock);
        reset = 1'b0; ifc.run = 1'b0; ifc.imem_ack = 1'b0;
        @(negedge clock);
        reset = 1'b1; ifc.run = 1'b1; ifc.imem_ack = 1'b1;
        ifc.op = OP_R; ifc.funct = F_AND; ifc.rd = 5'd7;
        #1;
        check("seq_idle_busy", 100, 32'(ifc.busy), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            #1;
            check("seq_imem_req",  100 + k, 32'(ifc.imem_req),  32'((k % 4) == 0));
            check("seq_ir_we",     100 + k, 32'(ifc.ir_we),     32'((k % 4) == 0));
            check("seq_pc_we",     100 + k, 32'(ifc.pc_we),     32'((k % 4) == 3));
            check("seq_reg_write", 100 + k, 32'(ifc.reg_write), 32'((k % 4) == 3));
            check("seq_aluop",     100 + k, 32'(ifc.aluop),     (k >= 2) ? 32'd4 : 32'd0);
        end
        @(negedge clock);
        #1;
        check("seq_instret", 108, ifc.instret, PERF ? 32'd2 : 32'd0);
        check("seq_cycles",  108, ifc.cycles,  PERF ? 32'd8 : 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencer for the R-type CPU datapath (PC, instruction memory, GPR file, ALU). It fetches each instruction from an instruction memory that may insert wait states, decodes `op` and `funct` from the instruction register, and issues one-cycle strobes: PC update, IR load, and GPR write. It traps on illegal encodings and on fetch timeouts. It replaces the free-running `pc+4` sequencing so that slow memories and halt/run control can be supported.

## Interface
Parameters:
- `TIMEOUT`, default 8'd255: maximum consecutive FETCH cycles without `imem_ack`. The value 0 disables the timeout.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous and active-low.
- `run`  in  1  level; allows a new fetch to start.
- `imem_ack`  in  1  instruction word valid this cycle.
- `op`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `rd`  in  5  IR[15:11].
- `imem_req`  out  1  fetch request.
- `ir_we`  out  1  load IR with the memory word.
- `pc_we`  out  1  PC <= PC+4.
- `reg_write`  out  1  GPR write enable.
- `aluop`  out  3  ALU operation select.
- `busy`  out  1  high in any state except IDLE and TRAP.
- `trap`  out  1  sticky; the controller is in TRAP.
- `trap_cause`  out  2  01 = illegal instruction, 10 = fetch timeout, 00 = none.
- `instret`  out  32  retired-instruction count (see Configuration).
- `cycles`  out  32  busy-cycle count (see Configuration).

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, TRAP. All are encoded in one state register.
- IDLE:
  - If `run`=1, go to FETCH. Otherwise stay in IDLE.
- FETCH:
  - `imem_req`=1.
  - If `imem_ack`=1, then `ir_we`=1 in the same cycle and the next state is DECODE.
  - Otherwise the wait counter increments.
  - If `TIMEOUT`≠0 and the counter reaches `TIMEOUT` without an ack, go to TRAP with cause 10.
  - The wait counter clears on every entry to FETCH.
- DECODE:
  - The instruction is legal when `op`=000000 and `funct` is one of: 100000 add, 100001 addu, 101010 slt, 100011 subu, 100100 and, 100101 or.
  - Legal: latch `aluop`<=`funct[2:0]` and go to EXEC.
  - Illegal: go to TRAP with cause 01. The aluop register is unchanged.
- EXEC:
  - No strobes. This cycle gives the ALU a full cycle to settle.
  - Next state is WB.
- WB:
  - `pc_we`=1.
  - `reg_write`=1 only if `rd`≠0. Writes to register 0 are suppressed, but the instruction still retires.
  - Next state: FETCH if `run`=1, else IDLE.
- TRAP:
  - All strobes are 0. `trap`=1 and `trap_cause` is held.
  - Only `reset` exits TRAP.
- `run` is sampled only in IDLE and WB. Dropping `run` mid-instruction lets the current instruction finish.
- `imem_ack` is ignored outside FETCH.
- `op`, `funct` and `rd` are sampled only in DECODE and WB. They must be stable from DECODE through WB (the IR is not reloaded until the next FETCH).

## Timing
- Strobes (`imem_req`, `ir_we`, `pc_we`, `reg_write`) are Moore outputs decoded from the state register. `ir_we` and `reg_write` additionally use the qualifying inputs described above.
- `aluop` is registered. It is valid from the first EXEC cycle and stays stable through WB and into the following FETCH.
- Minimum instruction time is 4 cycles (FETCH with same-cycle ack, then DECODE, EXEC, WB). Each cycle without an ack adds one cycle.
- The GPR write and the PC update both occur on the rising edge that ends WB.
- Reset (`reset`=0 at an edge) has priority over every transition, including mid-fetch and TRAP. After that edge:
  - state = IDLE
  - `aluop`=000, `trap`=0, `trap_cause`=00
  - all strobes = 0, `busy`=0
  - wait counter = 0, `instret`=0, `cycles`=0
- An outstanding fetch is abandoned by reset. A late `imem_ack` arriving after reset is ignored.
- Timeout boundary: an ack in the `TIMEOUT`-th FETCH cycle is accepted. If no ack arrives by then, the controller enters TRAP on that cycle's edge.
- Counters wrap modulo 2^32.

## Configuration
- `MC_CTRL_PERF_EN` defined:
  - `instret` increments on every WB cycle.
  - `cycles` increments on every cycle with `busy`=1.
- `MC_CTRL_PERF_EN` undefined:
  - `instret` and `cycles` are tied to 32'd0.
  - No counter flops are synthesized.
  - The port list is unchanged.

## Test plan
- Reset, then `run`=1 with `imem_ack` always 1, executing add rd=3 → repeating sequence FETCH/DECODE/EXEC/WB. `ir_we` pulses at cycle 0, `aluop`=000 in EXEC, `reg_write` and `pc_we` in WB (cycle 3), next `imem_req` at cycle 4. With PERF enabled, `instret`=1 after WB.
- Ack delayed 3 cycles, executing or rd=5 → FETCH lasts 4 cycles, `aluop`=101, instruction completes in 7 cycles, `cycles`=7.
- `funct`=100010 (sub), or `op`=000100 → TRAP after DECODE with `trap_cause`=01. No `reg_write` or `pc_we`. TRAP persists until `reset`=0.
- `TIMEOUT`=4: no ack → TRAP with cause 10 after exactly 4 FETCH cycles. Same test with ack on the 4th cycle → normal DECODE.
- slt with rd=0 → WB has `pc_we`=1 and `reg_write`=0, `instret` still increments. `run` dropped during EXEC → WB then IDLE, `busy`=0.
- `reset`=0 during FETCH with a later ack → IDLE, all outputs 0, and the late ack causes no `ir_we`.
